// File: rtl/bpu_pht_update_ctrl.sv
// bpu_pht_update_ctrl: round-robin merge of two branch-update ports into a FIFO feeding the PHT write side, plus PHT init sweep.
`timescale 1ns/1ps
module bpu_pht_update_ctrl #(
  parameter int K = 13,
  parameter int DEPTH = 4,
  parameter logic [1:0] INIT_VAL = 2'b01,
  parameter bit RST_SWEEP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic req0_valid,
  input  logic [31:0] req0_pc,
  input  logic req0_taken,
  output logic req0_ready,
  input  logic req1_valid,
  input  logic [31:0] req1_pc,
  input  logic req1_taken,
  output logic req1_ready,
  input  logic clear_req,
  output logic clear_busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic pht_update_en,
  output logic [31:0] pht_update_pc,
  output logic pht_actual_taken,
  output logic pht_init_en,
  output logic [K-1:0] pht_init_idx,
  output logic [1:0] pht_init_val
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_nx;
  logic [K-1:0] idx;
  logic [32:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic prefer1, grant0, grant1, idle, full, can_push, push, pop;
  always_comb begin
    idle = state == IDLE;
    full = count == CW'(DEPTH);
    grant0 = req0_valid && (!req1_valid || !prefer1);
    grant1 = req1_valid && (!req0_valid || prefer1);
    can_push = !rst && idle && !clear_req && !full;
    req0_ready = can_push && grant0;
    req1_ready = can_push && grant1;
    push = req0_ready || req1_ready;
    pop = idle && !clear_req && count != '0;
    state_nx = idle ? (clear_req ? SWEEP : IDLE) : (&idx ? IDLE : SWEEP);
  end
  assign clear_busy = state == SWEEP;
  assign pht_init_en = !rst && !idle;
  assign pht_init_idx = idx;
  assign pht_init_val = INIT_VAL;
  assign fifo_count = count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_SWEEP ? SWEEP : IDLE;
      idx <= '0;
    end else begin
      state <= state_nx;
      idx <= idle ? '0 : idx + K'(1);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= grant1 ? {req1_pc, req1_taken} : {req0_pc, req0_taken};
  // Any cycle not plainly issuing (sweep, or clear sampled) empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      prefer1 <= 1'b0;
    end else if (!idle || clear_req) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + CW'(push) - CW'(pop);
      prefer1 <= push ? grant0 : prefer1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pht_update_en <= 1'b0;
      pht_update_pc <= '0;
      pht_actual_taken <= 1'b0;
    end else begin
      pht_update_en <= pop;
      if (pop) {pht_update_pc, pht_actual_taken} <= mem[rd_ptr];
    end
  end
endmodule

// File: tb/tb_bpu_pht_update_ctrl.sv
// tb_bpu_pht_update_ctrl: directed scenarios for the PHT update sequencer (K=3, DEPTH=4).
`timescale 1ns/1ps
module tb_bpu_pht_update_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 0, req0_taken = 0, req1_valid = 0, req1_taken = 0, clear_req = 0;
  logic [31:0] req0_pc = 0, req1_pc = 0;
  logic req0_ready, req1_ready, clear_busy, pht_update_en, pht_actual_taken, pht_init_en;
  logic [2:0] fifo_count, pht_init_idx;
  logic [31:0] pht_update_pc;
  logic [1:0] pht_init_val;
  int n_chk = 0, n_fail = 0;
  logic [32:0] mq [$];
  logic m_en = 0, m_tk = 0;
  logic [31:0] m_pc = 0;
  always #5 clk = ~clk;
  bpu_pht_update_ctrl #(.K(3), .DEPTH(4), .INIT_VAL(2'b01), .RST_SWEEP(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_pc(req0_pc), .req0_taken(req0_taken), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_pc(req1_pc), .req1_taken(req1_taken), .req1_ready(req1_ready),
    .clear_req(clear_req), .clear_busy(clear_busy), .fifo_count(fifo_count),
    .pht_update_en(pht_update_en), .pht_update_pc(pht_update_pc), .pht_actual_taken(pht_actual_taken),
    .pht_init_en(pht_init_en), .pht_init_idx(pht_init_idx), .pht_init_val(pht_init_val));
  // Expected-queue model: pop the head at each edge, then enqueue what the bench expects to be accepted.
  task automatic tick(input bit push, input logic [31:0] pc, input logic tk, input bit clr);
    if (clr) begin
      mq.delete();
      m_en = 0;
    end else begin
      m_en = mq.size() != 0;
      if (m_en) {m_pc, m_tk} = mq.pop_front();
      if (push) mq.push_back({pc, tk});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1;
    req1_valid = 1;
    #1;
    n_chk++; if (clear_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy got %b exp 1", clear_busy); end
    n_chk++; if (pht_init_en !== 1'b0) begin n_fail++; $display("FAIL rst_init_en got %b exp 0", pht_init_en); end
    n_chk++; if (pht_update_en !== 1'b0) begin n_fail++; $display("FAIL rst_upd_en got %b exp 0", pht_update_en); end
    n_chk++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
    n_chk++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL rst_ready got %b exp 00", {req0_ready, req1_ready}); end
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_chk++; if ({pht_init_en, pht_init_idx, pht_init_val} !== {1'b1, 3'(i), 2'b01}) begin n_fail++; $display("FAIL sweep1_%0d got en=%b idx=%0d val=%b exp en=1 idx=%0d val=01", i, pht_init_en, pht_init_idx, pht_init_val, i); end
      n_chk++; if ({clear_busy, req0_ready, req1_ready, pht_update_en} !== 4'b1000) begin n_fail++; $display("FAIL sweep1_ctl_%0d got %b exp 1000", i, {clear_busy, req0_ready, req1_ready, pht_update_en}); end
      if (i == 7) begin req0_valid = 0; req1_valid = 0; end
      tick(0, 0, 0, 0);
    end
    n_chk++; if ({clear_busy, pht_init_en} !== 2'b00) begin n_fail++; $display("FAIL sweep1_end got %b exp 00", {clear_busy, pht_init_en}); end
  endtask
  task automatic test_single;
    req0_valid = 1; req0_pc = 32'h1000; req0_taken = 1;
    #1;
    n_chk++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready got %b exp 10", {req0_ready, req1_ready}); end
    tick(1, 32'h1000, 1, 0);
    req0_valid = 0;
    n_chk++; if ({fifo_count, pht_update_en} !== {3'd1, 1'b0}) begin n_fail++; $display("FAIL single_q got cnt=%0d en=%b exp 1,0", fifo_count, pht_update_en); end
    tick(0, 0, 0, 0);
    n_chk++; if ({pht_update_en, pht_update_pc, pht_actual_taken, fifo_count} !== {1'b1, 32'h1000, 1'b1, 3'd0}) begin n_fail++; $display("FAIL single_issue got en=%b pc=%h tk=%b cnt=%0d exp 1 1000 1 0", pht_update_en, pht_update_pc, pht_actual_taken, fifo_count); end
    tick(0, 0, 0, 0);
    n_chk++; if ({pht_update_en, pht_update_pc} !== {1'b0, 32'h1000}) begin n_fail++; $display("FAIL single_hold got en=%b pc=%h exp 0 1000", pht_update_en, pht_update_pc); end
  endtask
  task automatic test_alternate;
    bit exp = 1;
    req0_valid = 1; req0_pc = 32'h10; req0_taken = 0;
    req1_valid = 1; req1_pc = 32'h20; req1_taken = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin req0_valid = 0; req1_valid = 0; end
      #1;
      if (i < 6) begin
        n_chk++; if ({req0_ready, req1_ready} !== {!exp, exp}) begin n_fail++; $display("FAIL alt_grant_%0d got %b exp %b", i, {req0_ready, req1_ready}, {!exp, exp}); end
      end
      tick(i < 6, exp ? 32'h20 : 32'h10, exp, 0);
      n_chk++; if (pht_update_en !== m_en || (m_en && {pht_update_pc, pht_actual_taken} !== {m_pc, m_tk})) begin n_fail++; $display("FAIL alt_issue_%0d got en=%b pc=%h tk=%b exp en=%b pc=%h tk=%b", i, pht_update_en, pht_update_pc, pht_actual_taken, m_en, m_pc, m_tk); end
      n_chk++; if (fifo_count !== 3'(mq.size())) begin n_fail++; $display("FAIL alt_count_%0d got %0d exp %0d", i, fifo_count, mq.size()); end
      exp = !exp;
    end
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 7; i++) begin
      req1_valid = i < 5; req1_pc = 32'h100 + 32'(4 * i); req1_taken = i[0];
      #1;
      if (i < 5) begin
        n_chk++; if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_ready_%0d got %b exp 01", i, {req0_ready, req1_ready}); end
      end
      tick(i < 5, 32'h100 + 32'(4 * i), i[0], 0);
      n_chk++; if (fifo_count !== 3'(mq.size()) || fifo_count > 3'd4) begin n_fail++; $display("FAIL b2b_count_%0d got %0d exp %0d", i, fifo_count, mq.size()); end
      n_chk++; if (pht_update_en !== m_en || (m_en && {pht_update_pc, pht_actual_taken} !== {m_pc, m_tk})) begin n_fail++; $display("FAIL b2b_issue_%0d got en=%b pc=%h exp en=%b pc=%h", i, pht_update_en, pht_update_pc, m_en, m_pc); end
    end
  endtask
  task automatic test_clear_flush;
    req0_valid = 1; req0_pc = 32'h2000; req0_taken = 1;
    #1;
    tick(1, 32'h2000, 1, 0);
    req0_valid = 0;
    clear_req = 1;
    req1_valid = 1;
    #1;
    n_chk++; if ({fifo_count, req0_ready, req1_ready} !== {3'd1, 2'b00}) begin n_fail++; $display("FAIL clr_pre got cnt=%0d rdy=%b exp 1 00", fifo_count, {req0_ready, req1_ready}); end
    tick(0, 0, 0, 1);
    clear_req = 0;
    req1_valid = 0;
    n_chk++; if ({fifo_count, pht_update_en, clear_busy} !== {3'd0, 2'b01}) begin n_fail++; $display("FAIL clr_flush got cnt=%0d en=%b busy=%b exp 0 0 1", fifo_count, pht_update_en, clear_busy); end
    for (int i = 0; i < 8; i++) begin
      n_chk++; if ({pht_init_en, pht_init_idx, pht_update_en} !== {1'b1, 3'(i), 1'b0}) begin n_fail++; $display("FAIL clr_sweep_%0d got init=%b idx=%0d upd=%b exp 1 %0d 0", i, pht_init_en, pht_init_idx, pht_update_en, i); end
      clear_req = i == 3;
      tick(0, 0, 0, 0);
    end
    clear_req = 0;
    n_chk++; if ({clear_busy, pht_init_en, pht_update_en} !== 3'b000 || pht_update_pc !== m_pc) begin n_fail++; $display("FAIL clr_end got busy=%b init=%b upd=%b pc=%h exp 000 pc=%h", clear_busy, pht_init_en, pht_update_en, pht_update_pc, m_pc); end
  endtask
  task automatic test_reset_mid_sweep;
    clear_req = 1;
    tick(0, 0, 0, 1);
    clear_req = 0;
    repeat (5) tick(0, 0, 0, 0);
    n_chk++; if (pht_init_idx !== 3'd5) begin n_fail++; $display("FAIL mid_idx got %0d exp 5", pht_init_idx); end
    rst = 1;
    #1;
    mq.delete(); m_en = 0; m_pc = 0; m_tk = 0;
    n_chk++; if ({pht_init_en, pht_init_idx, pht_update_en, pht_update_pc, fifo_count, clear_busy} !== {1'b0, 3'd0, 1'b0, 32'h0, 3'd0, 1'b1}) begin n_fail++; $display("FAIL mid_rst got init=%b idx=%0d upd=%b pc=%h cnt=%0d busy=%b", pht_init_en, pht_init_idx, pht_update_en, pht_update_pc, fifo_count, clear_busy); end
    repeat (2) tick(0, 0, 0, 0);
    rst = 0;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_chk++; if ({pht_init_en, pht_init_idx, clear_busy} !== {1'b1, 3'(i), 1'b1}) begin n_fail++; $display("FAIL resweep_%0d got init=%b idx=%0d busy=%b exp 1 %0d 1", i, pht_init_en, pht_init_idx, clear_busy, i); end
      tick(0, 0, 0, 0);
    end
    n_chk++; if ({clear_busy, pht_init_en} !== 2'b00) begin n_fail++; $display("FAIL resweep_end got %b exp 00", {clear_busy, pht_init_en}); end
    req0_valid = 1; req0_pc = 32'h30; req0_taken = 0;
    req1_valid = 1; req1_pc = 32'h40; req1_taken = 1;
    #1;
    n_chk++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL rr_reset got %b exp 10", {req0_ready, req1_ready}); end
    tick(1, 32'h30, 0, 0);
    #1;
    n_chk++; if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL rr_next got %b exp 01", {req0_ready, req1_ready}); end
    req0_valid = 0; req1_valid = 0;
    #1;
    tick(0, 0, 0, 0);
    n_chk++; if ({pht_update_en, pht_update_pc, pht_actual_taken} !== {1'b1, 32'h30, 1'b0}) begin n_fail++; $display("FAIL rr_issue got en=%b pc=%h tk=%b exp 1 30 0", pht_update_en, pht_update_pc, pht_actual_taken); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_alternate;
    test_back_to_back;
    test_clear_flush;
    test_reset_mid_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
